// File: rtl/stack_master.sv
// Host-side sequencer for an attached stack: accepts one request at a time,
// issues at most one stack command, and returns a single response.
module stack_master #(
  parameter int unsigned m = 8,
  parameter int unsigned n = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [2:0]                 req_op,
  input  logic [n-1:0]               req_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [n-1:0]               rsp_data,
  output logic                       rsp_err,
  output logic [2:0]                 stk_cmd,
  output logic [n-1:0]               stk_data,
  input  logic [n-1:0]               stk_data_o,
  input  logic [3:0]                 stk_status,
  output logic [$clog2(m+1)-1:0]     depth,
  output logic                       sync_err
);

  localparam int unsigned DW = $clog2(m + 1);

  localparam logic [2:0] STK_NOP  = 3'd0;
  localparam logic [2:0] STK_PUSH = 3'd1;
  localparam logic [2:0] STK_POP  = 3'd2;
  localparam logic [2:0] STK_INC  = 3'd3;
  localparam logic [2:0] STK_DEC  = 3'd4;
  localparam logic [2:0] STK_LDI  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [n-1:0]   rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;
  logic [2:0]     stk_cmd_q, stk_cmd_d;
  logic [n-1:0]   stk_data_q, stk_data_d;
  logic [DW-1:0]  depth_q, depth_d;
  logic           sync_err_q, sync_err_d;
  logic           legal_c;

  wire st_empty = stk_status[0];
  wire st_full  = stk_status[1];

  // PEEK shares the NOP code; unknown codes are rejected.
  always_comb begin
    legal_c = 1'b0;
    case (req_op)
      STK_PUSH:                                 legal_c = !st_full;
      STK_NOP, STK_POP, STK_INC, STK_DEC, STK_LDI: legal_c = !st_empty;
      default:                                  legal_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    stk_cmd_d  = STK_NOP;
    stk_data_d = '0;
    depth_d    = depth_q;
    sync_err_d = sync_err_q;
    case (state_q)
      S_IDLE: begin
        if (((depth_q == '0) != st_empty) || ((depth_q == DW'(m)) != st_full))
          sync_err_d = 1'b1;
        if (req_valid) begin
          op_d       = req_op;
          rsp_data_d = '0;
          if (legal_c) begin
            state_d    = S_ISSUE;
            rsp_err_d  = 1'b0;
            stk_cmd_d  = req_op;
            stk_data_d = req_data;
          end else begin
            state_d   = S_RESP;
            rsp_err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        // The stack still shows the pre-pop top during the command cycle.
        if (op_q == STK_POP || op_q == STK_NOP)
          rsp_data_d = stk_data_o;
        if (op_q == STK_PUSH && depth_q != DW'(m))
          depth_d = depth_q + DW'(1);
        if (op_q == STK_POP && depth_q != '0)
          depth_d = depth_q - DW'(1);
        state_d = S_SETTLE;
      end
      S_SETTLE: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          state_d    = S_IDLE;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= STK_NOP;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      stk_cmd_q  <= STK_NOP;
      stk_data_q <= '0;
      depth_q    <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      stk_cmd_q  <= stk_cmd_d;
      stk_data_q <= stk_data_d;
      depth_q    <= depth_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign stk_cmd   = stk_cmd_q;
  assign stk_data  = stk_data_q;
  assign depth     = depth_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_stack_master.sv
// Scoreboard bench for stack_master driving a behavioural stack model.
module tb_stack_master;

  localparam int unsigned M = 8;
  localparam int unsigned N = 4;
  localparam int unsigned DW = $clog2(M + 1);

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] PUSH = 3'd1;
  localparam logic [2:0] POP  = 3'd2;
  localparam logic [2:0] INC  = 3'd3;
  localparam logic [2:0] DEC  = 3'd4;
  localparam logic [2:0] LDI  = 3'd5;

  logic          clk, rst;
  logic          req_valid, req_ready;
  logic [2:0]    req_op;
  logic [N-1:0]  req_data;
  logic          rsp_valid, rsp_ready;
  logic [N-1:0]  rsp_data;
  logic          rsp_err;
  logic [2:0]    stk_cmd;
  logic [N-1:0]  stk_data, stk_data_o;
  logic [3:0]    stk_status;
  logic [DW-1:0] depth;
  logic          sync_err;

  stack_master #(.m(M), .n(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stk_cmd(stk_cmd), .stk_data(stk_data), .stk_data_o(stk_data_o),
    .stk_status(stk_status), .depth(depth), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack
  logic [N-1:0] mem [M];
  int sp;
  int cmd_cnt;
  logic flip_empty;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp      <= 0;
      cmd_cnt <= 0;
    end else begin
      if (stk_cmd != NOP) cmd_cnt <= cmd_cnt + 1;
      case (stk_cmd)
        PUSH: if (sp < int'(M)) begin mem[3'(sp)] <= stk_data; sp <= sp + 1; end
        POP:  if (sp > 0) sp <= sp - 1;
        INC:  if (sp > 0) mem[3'(sp - 1)] <= mem[3'(sp - 1)] + N'(1);
        DEC:  if (sp > 0) mem[3'(sp - 1)] <= mem[3'(sp - 1)] - N'(1);
        LDI:  if (sp > 0) mem[3'(sp - 1)] <= stk_data;
        default: ;
      endcase
    end
  end

  assign stk_data_o = (sp > 0) ? mem[3'(sp - 1)] : '0;
  assign stk_status = {2'b00, sp == int'(M), (sp == 0) ^ flip_empty};

  typedef struct {
    logic         err;
    logic [N-1:0] data;
    int           lat;
    time          t_acc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int exp_cmds = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each response handshake
  logic         in_rsp = 1'b0;
  logic [N-1:0] hold_data;
  logic         hold_err;

  always @(negedge clk) begin
    if (rst) begin
      in_rsp = 1'b0;
    end else if (rsp_valid) begin
      chk("req_ready_in_resp", 32'(req_ready), 32'd0);
      if (!in_rsp) begin
        in_rsp    = 1'b1;
        hold_data = rsp_data;
        hold_err  = rsp_err;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected none at %0t", $time);
        end else begin
          chk("latency", 32'(int'(($time - q[0].t_acc + 5) / 10)), 32'(q[0].lat));
        end
      end else begin
        chk("stable_data", 32'(rsp_data), 32'(hold_data));
        chk("stable_err", 32'(rsp_err), 32'(hold_err));
      end
      if (rsp_ready) begin
        in_rsp = 1'b0;
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end
    end
  end

  task automatic do_req(input logic [2:0] op, input logic [N-1:0] d,
                        input logic err, input logic [N-1:0] rd);
    exp_t e;
    int budget;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_data = d;
    budget = 0;
    while (!req_ready && budget < 50) begin @(negedge clk); budget++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.err = err; e.data = rd; e.lat = err ? 1 : 3; e.t_acc = $time;
    q.push_back(e);
    if (!err && op != NOP) exp_cmds++;
    @(negedge clk);
    req_valid = 1'b0;
    chk("issue_cmd", 32'(stk_cmd), err ? 32'(NOP) : 32'(op));
    chk("issue_data", 32'(stk_data), err ? 32'd0 : 32'(d));
    if (!err) begin
      @(negedge clk);
      chk("settle_cmd", 32'(stk_cmd), 32'(NOP));
      chk("settle_data", 32'(stk_data), 32'd0);
    end
  endtask

  task automatic wait_idle();
    int budget = 0;
    @(negedge clk);
    while ((q.size() != 0 || !req_ready) && budget < 100) begin @(negedge clk); budget++; end
    if (q.size() != 0 || !req_ready) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got pending=%0d expected 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = NOP; req_data = '0;
    rsp_ready = 1'b1; flip_empty = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_stk_cmd", 32'(stk_cmd), 32'(NOP));
    chk("rst_stk_data", 32'(stk_data), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Empty-stack rejections
    do_req(NOP, 4'd0, 1'b1, 4'd0);
    do_req(LDI, 4'd3, 1'b1, 4'd0);

    for (int i = 1; i <= 8; i++) do_req(PUSH, N'(i), 1'b0, 4'd0);
    wait_idle();
    chk("depth_full", 32'(depth), 32'd8);
    chk("status_full", 32'(stk_status[1]), 32'd1);

    do_req(PUSH, 4'd9, 1'b1, 4'd0);
    wait_idle();
    chk("depth_after_rej", 32'(depth), 32'd8);
    chk("cmds_after_rej", 32'(cmd_cnt), 32'(exp_cmds));

    do_req(INC, 4'd0, 1'b0, 4'd0);
    @(posedge clk); #1 rsp_ready = 1'b0;
    fork
      begin
        do_req(NOP, 4'd0, 1'b0, 4'd9);
        do_req(DEC, 4'd0, 1'b0, 4'd0);
      end
      begin
        repeat (10) @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    do_req(POP, 4'd0, 1'b0, 4'd8);
    wait_idle();
    chk("depth_7", 32'(depth), 32'd7);

    for (int i = 7; i >= 1; i--) do_req(POP, 4'd0, 1'b0, N'(i));
    do_req(POP, 4'd0, 1'b1, 4'd0);
    wait_idle();
    chk("depth_empty", 32'(depth), 32'd0);
    chk("sync_err_clean", 32'(sync_err), 32'd0);

    do_req(PUSH, 4'd3, 1'b0, 4'd0);
    do_req(LDI, 4'd5, 1'b0, 4'd0);
    do_req(POP, 4'd0, 1'b0, 4'd5);
    wait_idle();
    chk("cmds_total", 32'(cmd_cnt), 32'(exp_cmds));

    // Reset while a PUSH is in its command cycle
    @(negedge clk);
    req_valid = 1'b1; req_op = PUSH; req_data = 4'd7;
    @(posedge clk);
    #1 chk("mid_issue_cmd", 32'(stk_cmd), 32'(PUSH));
    #1 rst = 1'b1;
    #1;
    chk("async_rst_cmd", 32'(stk_cmd), 32'(NOP));
    chk("async_rst_data", 32'(stk_data), 32'd0);
    chk("async_rst_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_depth", 32'(depth), 32'd0);
    chk("post_rst_stack", 32'(sp), 32'd0);
    chk("post_rst_cmds", 32'(cmd_cnt), 32'd0);

    // Sticky occupancy mismatch flag
    flip_empty = 1'b1;
    @(negedge clk);
    chk("sync_err_set", 32'(sync_err), 32'd1);
    flip_empty = 1'b0;
    @(negedge clk);
    chk("sync_err_sticky", 32'(sync_err), 32'd1);
    rst = 1'b1;
    #1 chk("sync_err_rst", 32'(sync_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
